// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and types for the hazard scoreboard
package hazard_pkg;

  localparam int REG_ZERO         = 0;
  localparam int LOAD_LATENCY_MAX = 7;

  typedef logic [31:0] perf_cnt_t;

  localparam perf_cnt_t PERF_CNT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic pc_write;
    logic id_write;
    logic stall;
    logic flush_if_id;
    logic flush_id_ex;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_CTRL_RUN = '{pc_write: 1'b1, id_write: 1'b1, stall: 1'b0,
                                       flush_if_id: 1'b0, flush_id_ex: 1'b0};

endpackage

// File: rtl/hazard_reg_counter.sv
// rtl/hazard_reg_counter.sv - per-register load-use countdown with load/cancel/decrement
module hazard_reg_counter #(
  parameter int CNT_WIDTH  = 2,
  parameter int LOAD_VALUE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_en,
  input  logic load_mem,
  output logic busy
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // A new write always wins over the running countdown; a non-load write cancels it.
  always_comb begin
    cnt_d = cnt_q;
    if (load_en) begin
      cnt_d = load_mem ? CNT_WIDTH'(LOAD_VALUE) : '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - ID-stage countdown scoreboard and branch flush; HAZARD_PERF_CNT_EN adds cycle counters
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int  REG_ADDR_WIDTH = 5,
  parameter int  LOAD_LATENCY   = 2,
  localparam int CNT_WIDTH      = $clog2(LOAD_LATENCY + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_mem_read,
  input  logic                      id_reg_write,
  input  logic                      ex_branch_taken,
  output logic                      pc_write,
  output logic                      id_write,
  output logic                      stall,
  output logic                      flush_if_id,
  output logic                      flush_id_ex
`ifdef HAZARD_PERF_CNT_EN
  ,
  output perf_cnt_t                 stall_cycles,
  output perf_cnt_t                 flush_cycles
`endif
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] X0 = REG_ADDR_WIDTH'(REG_ZERO);

  if (LOAD_LATENCY < 1 || LOAD_LATENCY > LOAD_LATENCY_MAX) begin : g_bad_latency
    $error("hazard_scoreboard_unit: LOAD_LATENCY out of range");
  end

  logic [NUM_REGS-1:0] busy;
  logic                hz;
  logic                advance;
  hz_ctrl_t            ctrl;

  assign busy[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
    hazard_reg_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .LOAD_VALUE(LOAD_LATENCY)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_en (advance && id_reg_write && (id_rd == REG_ADDR_WIDTH'(g))),
      .load_mem(id_mem_read),
      .busy    (busy[g])
    );
  end

  assign hz = id_valid &&
              ((id_rs1_used && (id_rs1 != X0) && busy[id_rs1]) ||
               (id_rs2_used && (id_rs2 != X0) && busy[id_rs2]));

  assign advance = id_valid && !hz && !ex_branch_taken;

  // Outputs are pinned to the free-running state while reset is held, whatever the inputs.
  always_comb begin
    ctrl = HZ_CTRL_RUN;
    if (rst_n) begin
      if (ex_branch_taken) begin
        ctrl.flush_if_id = 1'b1;
        ctrl.flush_id_ex = 1'b1;
      end else if (hz) begin
        ctrl.pc_write = 1'b0;
        ctrl.id_write = 1'b0;
        ctrl.stall    = 1'b1;
      end
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign id_write    = ctrl.id_write;
  assign stall       = ctrl.stall;
  assign flush_if_id = ctrl.flush_if_id;
  assign flush_id_ex = ctrl.flush_id_ex;

`ifdef HAZARD_PERF_CNT_EN
  perf_cnt_t stall_cycles_q, stall_cycles_d;
  perf_cnt_t flush_cycles_q, flush_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (ctrl.stall && stall_cycles_q != PERF_CNT_MAX) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (ctrl.flush_id_ex && flush_cycles_q != PERF_CNT_MAX) begin
      flush_cycles_d = flush_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used;
  logic       id_mem_read, id_reg_write, ex_branch_taken;
  logic       pc_write, id_write, stall, flush_if_id, flush_id_ex;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  // {pc_write, id_write, stall, flush_if_id, flush_id_ex}
  localparam logic [4:0] RUN = 5'b11000;
  localparam logic [4:0] STL = 5'b00100;
  localparam logic [4:0] FLS = 5'b11011;

  logic [4:0] outs;
  assign outs = {pc_write, id_write, stall, flush_if_id, flush_id_ex};

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_rd          (id_rd),
    .id_mem_read    (id_mem_read),
    .id_reg_write   (id_reg_write),
    .ex_branch_taken(ex_branch_taken),
    .pc_write       (pc_write),
    .id_write       (id_write),
    .stall          (stall),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_cycles   (flush_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic rw, input logic br);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_mem_read = mr; id_reg_write = rw; ex_branch_taken = br;
  endtask

  task automatic load(input logic [4:0] rd);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic read1(input logic [4:0] rs, input logic br);
    drive(1'b1, rs, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, br);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs are set just after a rising edge, outputs compared on the falling edge.
  task automatic cyc(input string tag, input logic [4:0] exp);
    @(negedge clk);
    check(tag, 32'(outs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc("rst_forced", RUN);
    rst_n = 1'b1;
    read1(5'd5, 1'b0);
    cyc("post_rst_clear", RUN);

    load(5'd5);           cyc("t2_load", RUN);
    read1(5'd5, 1'b0);    cyc("t2_stall1", STL);
                          cyc("t2_stall2", STL);
                          cyc("t2_advance", RUN);

    load(5'd0);           cyc("t3_load_x0", RUN);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
                          cyc("t3_read_x0", RUN);
    load(5'd5);           cyc("t3_load_x5", RUN);
    drive(1'b1, 5'd1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
                          cyc("t3_rs2_unused", RUN);
    idle();               cyc("t3_idle1", RUN);
                          cyc("t3_idle2", RUN);

    load(5'd7);           cyc("t4_load_x7", RUN);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
                          cyc("t4_alu_x7", RUN);
    read1(5'd7, 1'b0);    cyc("t4_cancel", RUN);

    load(5'd9);           cyc("t5_load_x9", RUN);
    read1(5'd9, 1'b1);    cyc("t5_flush", FLS);
    read1(5'd9, 1'b0);    cyc("t5_tail_stall", STL);
                          cyc("t5_advance", RUN);

    load(5'd5);           cyc("rst_mid_load", RUN);
    read1(5'd5, 1'b0);
    @(negedge clk);
    check("rst_mid_stall", 32'(outs), 32'(STL));
    #2 rst_n = 1'b0;
    #1 check("rst_async", 32'(outs), 32'(RUN));
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("rst_release", RUN);

`ifdef HAZARD_PERF_CNT_EN
    load(5'd5);           cyc("perf_load", RUN);
    read1(5'd5, 1'b0);    cyc("perf_stall1", STL);
                          cyc("perf_stall2", STL);
                          cyc("perf_advance", RUN);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
                          cyc("perf_branch", FLS);
    idle();
    check("perf_stall_cycles", stall_cycles, 32'd2);
    check("perf_flush_cycles", flush_cycles, 32'd1);

    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cycles_q;
    load(5'd6);           cyc("sat_load", RUN);
    read1(5'd6, 1'b0);    cyc("sat_stall1", STL);
                          cyc("sat_stall2", STL);
    check("perf_saturate", stall_cycles, 32'hFFFF_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
